// File: rtl/ctrl_pipe.sv
// ctrl_pipe: pipeline control-bundle carrier for a 5-stage datapath.
// Takes the WB/M/EX control bundle from the decoder at ID and moves it through the
// ID/EX, EX/MEM and MEM/WB control registers. Destination registers are tracked
// alongside. The block inserts load-use bubbles, squashes on flush, and keeps
// saturating stall and flush event counters.
module ctrl_pipe #(
   parameter int unsigned REG_W = 5,
   parameter int unsigned CNT_W = 16
) (
   input  logic             i_clk,
   input  logic             i_rst,
   // Decoder bundle: wb[1]=RegWrite wb[0]=MemtoReg
   input  logic [1:0]       i_wb_in,
   // m[2]=Branch m[1]=MemRead m[0]=MemWrite
   input  logic [2:0]       i_m_in,
   // ex[3]=RegDst ex[2:1]=ALUOp ex[0]=ALUSrc
   input  logic [3:0]       i_ex_in,
   input  logic [REG_W-1:0] i_id_rs,
   input  logic [REG_W-1:0] i_id_rt,
   input  logic [REG_W-1:0] i_id_rd,
   input  logic             i_flush,
   input  logic             i_mem_zero,
   output logic             o_stall,
   output logic             o_ex_regdst,
   output logic [1:0]       o_ex_aluop,
   output logic             o_ex_alusrc,
   output logic [REG_W-1:0] o_ex_rs,
   output logic [REG_W-1:0] o_ex_rt,
   output logic             o_mem_branch,
   output logic             o_mem_memread,
   output logic             o_mem_memwrite,
   output logic             o_mem_regwrite,
   output logic [REG_W-1:0] o_mem_dest,
   output logic             o_pc_src,
   output logic             o_wb_regwrite,
   output logic             o_wb_memtoreg,
   output logic [REG_W-1:0] o_wb_dest,
   output logic [CNT_W-1:0] o_stall_cnt,
   output logic [CNT_W-1:0] o_flush_cnt
);

   // ID/EX stage registers
   logic [1:0]       r_idex_wb;
   logic [2:0]       r_idex_m;
   logic [3:0]       r_idex_ex;
   logic [REG_W-1:0] r_idex_rs;
   logic [REG_W-1:0] r_idex_rt;
   logic [REG_W-1:0] r_idex_rd;

   // EX/MEM stage registers
   logic [1:0]       r_exmem_wb;
   logic [2:0]       r_exmem_m;
   logic [REG_W-1:0] r_exmem_dest;

   // MEM/WB stage registers
   logic [1:0]       r_memwb_wb;
   logic [REG_W-1:0] r_memwb_dest;

   // Performance counters
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_flush_cnt;

   logic             w_stall;
   logic             w_idex_bubble;
   logic             w_rt_nonzero;
   logic             w_rt_match;
   logic [REG_W-1:0] w_ex_dest;
   logic             w_stall_cnt_max;
   logic             w_flush_cnt_max;

   // Load-use hazard: a load in EX whose target is read by the instruction in ID.
   // Register 0 is hardwired, so a load targeting it never creates a dependency.
   assign w_rt_nonzero  = (r_idex_rt != '0);
   assign w_rt_match    = (r_idex_rt == i_id_rs) | (r_idex_rt == i_id_rt);
   assign w_stall       = r_idex_m[1] & w_rt_nonzero & w_rt_match;

   // Flush and stall both turn the ID/EX control fields into a bubble.
   assign w_idex_bubble = i_flush | w_stall;

   // Destination select in EX: rd for R-type (RegDst=1), rt otherwise.
   assign w_ex_dest     = r_idex_ex[3] ? r_idex_rd : r_idex_rt;

   assign w_stall_cnt_max = &r_stall_cnt;
   assign w_flush_cnt_max = &r_flush_cnt;

   // ID/EX control fields: capture the decoder bundle, or zero it for a bubble/squash.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_idex_wb <= 2'b00;
         r_idex_m  <= 3'b000;
         r_idex_ex <= 4'b0000;
      end else if (w_idex_bubble) begin
         r_idex_wb <= 2'b00;
         r_idex_m  <= 3'b000;
         r_idex_ex <= 4'b0000;
      end else begin
         r_idex_wb <= i_wb_in;
         r_idex_m  <= i_m_in;
         r_idex_ex <= i_ex_in;
      end
   end

   // ID/EX register specifiers: loaded every cycle, even on bubble or squash.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_idex_rs <= '0;
         r_idex_rt <= '0;
         r_idex_rd <= '0;
      end else begin
         r_idex_rs <= i_id_rs;
         r_idex_rt <= i_id_rt;
         r_idex_rd <= i_id_rd;
      end
   end

   // EX/MEM control fields: advance from ID/EX, zeroed on flush.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_exmem_wb <= 2'b00;
         r_exmem_m  <= 3'b000;
      end else if (i_flush) begin
         r_exmem_wb <= 2'b00;
         r_exmem_m  <= 3'b000;
      end else begin
         r_exmem_wb <= r_idex_wb;
         r_exmem_m  <= r_idex_m;
      end
   end

   // EX/MEM destination register: always advances.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_exmem_dest <= '0;
      end else begin
         r_exmem_dest <= w_ex_dest;
      end
   end

   // MEM/WB stage: advances unconditionally. Flush does not reach WB.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_memwb_wb   <= 2'b00;
         r_memwb_dest <= '0;
      end else begin
         r_memwb_wb   <= r_exmem_wb;
         r_memwb_dest <= r_exmem_dest;
      end
   end

   // Stall event counter: counts cycles with stall asserted and sticks at all-ones.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_stall_cnt <= '0;
      end else if (w_stall && !w_stall_cnt_max) begin
         r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
   end

   // Flush event counter: counts cycles with flush asserted and sticks at all-ones.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_flush_cnt <= '0;
      end else if (i_flush && !w_flush_cnt_max) begin
         r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
   end

   // Output mapping. Only stall and pc_src are combinational.
   assign o_stall        = w_stall;
   assign o_ex_regdst    = r_idex_ex[3];
   assign o_ex_aluop     = r_idex_ex[2:1];
   assign o_ex_alusrc    = r_idex_ex[0];
   assign o_ex_rs        = r_idex_rs;
   assign o_ex_rt        = r_idex_rt;
   assign o_mem_branch   = r_exmem_m[2];
   assign o_mem_memread  = r_exmem_m[1];
   assign o_mem_memwrite = r_exmem_m[0];
   assign o_mem_regwrite = r_exmem_wb[1];
   assign o_mem_dest     = r_exmem_dest;
   assign o_pc_src       = r_exmem_m[2] & i_mem_zero;
   assign o_wb_regwrite  = r_memwb_wb[1];
   assign o_wb_memtoreg  = r_memwb_wb[0];
   assign o_wb_dest      = r_memwb_dest;
   assign o_stall_cnt    = r_stall_cnt;
   assign o_flush_cnt    = r_flush_cnt;

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe: directed scoreboard bench for ctrl_pipe.
// The driver pushes hand-computed expectations, tagged with a cycle number, as it
// applies each vector. A monitor pops those expectations on the falling edge and
// compares them. Counters are built 4 bits wide so that saturation is reachable.
module tb_ctrl_pipe;

   localparam int unsigned REG_W = 5;
   localparam int unsigned CNT_W = 4;

   // Output selectors
   localparam int S_STALL    = 0;
   localparam int S_REGDST   = 1;
   localparam int S_ALUOP    = 2;
   localparam int S_ALUSRC   = 3;
   localparam int S_EXRS     = 4;
   localparam int S_EXRT     = 5;
   localparam int S_BRANCH   = 6;
   localparam int S_MEMREAD  = 7;
   localparam int S_MEMWRITE = 8;
   localparam int S_MEMREGWR = 9;
   localparam int S_MEMDEST  = 10;
   localparam int S_PCSRC    = 11;
   localparam int S_WBREGWR  = 12;
   localparam int S_WBM2R    = 13;
   localparam int S_WBDEST   = 14;
   localparam int S_STALLCNT = 15;
   localparam int S_FLUSHCNT = 16;
   localparam int N_SIG      = 17;

   logic             clk = 1'b0;
   logic             rst;
   logic [1:0]       wb_in;
   logic [2:0]       m_in;
   logic [3:0]       ex_in;
   logic [REG_W-1:0] id_rs, id_rt, id_rd;
   logic             flush, mem_zero;

   logic             stall, ex_regdst, ex_alusrc, mem_branch, mem_memread, mem_memwrite;
   logic             mem_regwrite, pc_src, wb_regwrite, wb_memtoreg;
   logic [1:0]       ex_aluop;
   logic [REG_W-1:0] ex_rs, ex_rt, mem_dest, wb_dest;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;

   typedef struct {
      int          cyc;
      string       name;
      int          sig;
      logic [31:0] exp;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;

   ctrl_pipe #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
      .i_clk(clk), .i_rst(rst), .i_wb_in(wb_in), .i_m_in(m_in), .i_ex_in(ex_in),
      .i_id_rs(id_rs), .i_id_rt(id_rt), .i_id_rd(id_rd), .i_flush(flush),
      .i_mem_zero(mem_zero), .o_stall(stall), .o_ex_regdst(ex_regdst),
      .o_ex_aluop(ex_aluop), .o_ex_alusrc(ex_alusrc), .o_ex_rs(ex_rs), .o_ex_rt(ex_rt),
      .o_mem_branch(mem_branch), .o_mem_memread(mem_memread),
      .o_mem_memwrite(mem_memwrite), .o_mem_regwrite(mem_regwrite), .o_mem_dest(mem_dest),
      .o_pc_src(pc_src), .o_wb_regwrite(wb_regwrite), .o_wb_memtoreg(wb_memtoreg),
      .o_wb_dest(wb_dest), .o_stall_cnt(stall_cnt), .o_flush_cnt(flush_cnt)
   );

   always #5 clk = ~clk;

   // Cycle tag shared by driver and monitor
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] sig_val(int s);
      case (s)
         S_STALL:    sig_val = 32'(stall);
         S_REGDST:   sig_val = 32'(ex_regdst);
         S_ALUOP:    sig_val = 32'(ex_aluop);
         S_ALUSRC:   sig_val = 32'(ex_alusrc);
         S_EXRS:     sig_val = 32'(ex_rs);
         S_EXRT:     sig_val = 32'(ex_rt);
         S_BRANCH:   sig_val = 32'(mem_branch);
         S_MEMREAD:  sig_val = 32'(mem_memread);
         S_MEMWRITE: sig_val = 32'(mem_memwrite);
         S_MEMREGWR: sig_val = 32'(mem_regwrite);
         S_MEMDEST:  sig_val = 32'(mem_dest);
         S_PCSRC:    sig_val = 32'(pc_src);
         S_WBREGWR:  sig_val = 32'(wb_regwrite);
         S_WBM2R:    sig_val = 32'(wb_memtoreg);
         S_WBDEST:   sig_val = 32'(wb_dest);
         S_STALLCNT: sig_val = 32'(stall_cnt);
         S_FLUSHCNT: sig_val = 32'(flush_cnt);
         default:    sig_val = 32'hxxxx_xxxx;
      endcase
   endfunction

   // Monitor: compare every expectation due in the current cycle.
   initial begin
      exp_t        e;
      logic [31:0] act;
      forever begin
         @(negedge clk);
         while (q.size() > 0 && q[0].cyc <= cyc) begin
            e   = q.pop_front();
            act = sig_val(e.sig);
            n_tests++;
            if (act !== e.exp) begin
               n_fail++;
               $display("FAIL %s (cycle %0d): got %0h, expected %0h", e.name, e.cyc, act, e.exp);
            end
         end
      end
   end

   task automatic chk(input string name, input int sig, input logic [31:0] val);
      exp_t e;
      e.cyc  = cyc;
      e.name = name;
      e.sig  = sig;
      e.exp  = val;
      q.push_back(e);
   endtask

   task automatic chk_all_zero(input string name);
      for (int s = 0; s < N_SIG; s++) chk($sformatf("%s[%0d]", name, s), s, 32'd0);
   endtask

   // Advance one clock; inputs are then driven 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drv(input logic [1:0] wb, input logic [2:0] m, input logic [3:0] ex,
                      input int rs, input int rt, input int rd);
      wb_in = wb;
      m_in  = m;
      ex_in = ex;
      id_rs = REG_W'(rs);
      id_rt = REG_W'(rt);
      id_rd = REG_W'(rd);
   endtask

   task automatic nop();
      drv(2'b00, 3'b000, 4'b0000, 0, 0, 0);
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; mem_zero = 1'b0;
      nop();
      step();
      step();
      chk_all_zero("reset");
      rst = 1'b0;
      step();

      // 1: R-type traverses EX, MEM, WB
      drv(2'b10, 3'b000, 4'b1100, 1, 3, 5);
      chk("r_pre_stall", S_STALL, 0);
      step(); nop();
      chk("r_ex_regdst", S_REGDST, 1); chk("r_ex_aluop", S_ALUOP, 2);
      chk("r_ex_alusrc", S_ALUSRC, 0); chk("r_ex_rs", S_EXRS, 1); chk("r_ex_rt", S_EXRT, 3);
      step(); nop();
      chk("r_mem_regwr", S_MEMREGWR, 1); chk("r_mem_dest", S_MEMDEST, 5);
      chk("r_ex_cleared", S_REGDST, 0);
      step(); nop();
      chk("r_wb_regwr", S_WBREGWR, 1); chk("r_wb_m2r", S_WBM2R, 0);
      chk("r_wb_dest", S_WBDEST, 5); chk("r_mem_cleared", S_MEMREGWR, 0);

      // 2: lw rt=4 followed by a reader of r4
      step(); drv(2'b11, 3'b010, 4'b0001, 1, 4, 0);
      step(); drv(2'b10, 3'b000, 4'b1100, 4, 2, 6);
      chk("lu_stall", S_STALL, 1); chk("lu_ex_lw", S_ALUSRC, 1); chk("lu_cnt0", S_STALLCNT, 0);
      step(); drv(2'b10, 3'b000, 4'b1100, 4, 2, 6);
      chk("lu_stall_once", S_STALL, 0); chk("lu_bub_regdst", S_REGDST, 0);
      chk("lu_bub_aluop", S_ALUOP, 0); chk("lu_bub_alusrc", S_ALUSRC, 0);
      chk("lu_bub_rs", S_EXRS, 4); chk("lu_cnt1", S_STALLCNT, 1);
      chk("lu_mem_rd", S_MEMREAD, 1); chk("lu_mem_dest", S_MEMDEST, 4);
      step(); nop();
      chk("lu_ex_add", S_REGDST, 1); chk("lu_mem_bub", S_MEMREAD, 0);
      chk("lu_mem_bub_wr", S_MEMREGWR, 0); chk("lu_wb_regwr", S_WBREGWR, 1);
      chk("lu_wb_m2r", S_WBM2R, 1); chk("lu_wb_dest", S_WBDEST, 4);
      step(); nop();
      chk("lu_add_mem_regwr", S_MEMREGWR, 1); chk("lu_add_mem_dest", S_MEMDEST, 6);

      // 3: lw targeting r0 never stalls
      step(); drv(2'b11, 3'b010, 4'b0001, 1, 0, 0);
      step(); nop();
      chk("r0_no_stall", S_STALL, 0); chk("r0_ex_lw", S_ALUSRC, 1);
      step(); nop();
      chk("r0_mem_rd", S_MEMREAD, 1); chk("r0_cnt", S_STALLCNT, 1);

      // 4: taken beq in MEM, flush squashes ID/EX and EX/MEM
      step(); drv(2'b10, 3'b000, 4'b1100, 0, 7, 8);
      step(); drv(2'b00, 3'b100, 4'b0010, 1, 2, 0);
      step(); drv(2'b10, 3'b000, 4'b1100, 0, 0, 9);
      step(); drv(2'b10, 3'b000, 4'b1100, 1, 1, 10); flush = 1'b1; mem_zero = 1'b1;
      chk("br_pc_src", S_PCSRC, 1); chk("br_mem_branch", S_BRANCH, 1);
      chk("br_mem_dest", S_MEMDEST, 2); chk("br_wb_regwr", S_WBREGWR, 1);
      chk("br_wb_dest", S_WBDEST, 8); chk("br_ex_regdst", S_REGDST, 1);
      chk("br_fcnt0", S_FLUSHCNT, 0);
      step(); nop(); flush = 1'b0;
      chk("fl_ex_regdst", S_REGDST, 0); chk("fl_ex_aluop", S_ALUOP, 0);
      chk("fl_ex_rt", S_EXRT, 1); chk("fl_mem_regwr", S_MEMREGWR, 0);
      chk("fl_mem_branch", S_BRANCH, 0); chk("fl_mem_dest", S_MEMDEST, 9);
      chk("fl_pc_src", S_PCSRC, 0); chk("fl_wb_regwr", S_WBREGWR, 0);
      chk("fl_wb_dest", S_WBDEST, 2); chk("fl_fcnt1", S_FLUSHCNT, 1);
      step(); nop(); mem_zero = 1'b0;
      chk("fl2_wb_regwr", S_WBREGWR, 0); chk("fl2_wb_dest", S_WBDEST, 9);
      chk("fl2_mem_regwr", S_MEMREGWR, 0); chk("fl2_mem_dest", S_MEMDEST, 1);

      // 5: flush and stall in the same cycle
      step(); drv(2'b11, 3'b010, 4'b0001, 0, 5, 0);
      step(); drv(2'b10, 3'b000, 4'b1100, 5, 3, 11); flush = 1'b1;
      chk("fs_stall", S_STALL, 1); chk("fs_scnt", S_STALLCNT, 1); chk("fs_fcnt", S_FLUSHCNT, 1);
      step(); nop(); flush = 1'b0;
      chk("fs_no_stall", S_STALL, 0); chk("fs_ex_alusrc", S_ALUSRC, 0);
      chk("fs_ex_rs", S_EXRS, 5); chk("fs_mem_rd", S_MEMREAD, 0);
      chk("fs_mem_regwr", S_MEMREGWR, 0); chk("fs_mem_dest", S_MEMDEST, 5);
      chk("fs_scnt2", S_STALLCNT, 2); chk("fs_fcnt2", S_FLUSHCNT, 2);
      step(); nop();
      chk("fs_wb_regwr", S_WBREGWR, 0); chk("fs_wb_m2r", S_WBM2R, 0);
      chk("fs_wb_dest", S_WBDEST, 5);

      // Stall counter saturation: one stall per iteration, capped at 15
      for (int i = 0; i < 16; i++) begin
         step(); drv(2'b11, 3'b010, 4'b0001, 0, 5, 0);
         step(); drv(2'b10, 3'b000, 4'b1100, 5, 3, 11);
         chk($sformatf("sat_stall_%0d", i), S_STALL, 1);
         chk($sformatf("sat_scnt_%0d", i), S_STALLCNT, (i + 2 > 15) ? 15 : i + 2);
      end
      step(); nop();
      chk("sat_scnt_final", S_STALLCNT, 15);

      // Flush counter saturation
      for (int k = 0; k < 20; k++) begin
         step(); nop(); flush = 1'b1;
         chk($sformatf("sat_fcnt_%0d", k), S_FLUSHCNT, (k + 2 > 15) ? 15 : k + 2);
      end
      step(); nop(); flush = 1'b0;
      chk("sat_fcnt_final", S_FLUSHCNT, 15);

      // 6: reset with three bundles in flight, then a store
      step(); drv(2'b10, 3'b000, 4'b1100, 0, 0, 12);
      step(); drv(2'b11, 3'b010, 4'b0001, 0, 13, 0);
      step(); drv(2'b00, 3'b001, 4'b0001, 0, 14, 0);
      step(); nop(); rst = 1'b1;
      chk("inf_wb_regwr", S_WBREGWR, 1); chk("inf_wb_dest", S_WBDEST, 12);
      chk("inf_mem_rd", S_MEMREAD, 1); chk("inf_mem_dest", S_MEMDEST, 13);
      chk("inf_ex_alusrc", S_ALUSRC, 1);
      step(); drv(2'b00, 3'b001, 4'b0001, 2, 15, 0); rst = 1'b0;
      chk_all_zero("midrst");
      step(); nop();
      chk("sw_ex_alusrc", S_ALUSRC, 1); chk("sw_ex_rt", S_EXRT, 15);
      chk("sw_mem_wr_early", S_MEMWRITE, 0);
      step(); nop();
      chk("sw_mem_wr", S_MEMWRITE, 1); chk("sw_mem_dest", S_MEMDEST, 15);
      step(); nop();
      chk("sw_mem_wr_gone", S_MEMWRITE, 0); chk("sw_wb_dest", S_WBDEST, 15);

      // Bounded drain of the scoreboard
      for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
      #1;
      if (q.size() > 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d pending, expected 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
